memory_burst: RTL and testbench

Parametrised successor to the single-beat `memory1` slave. It is a synchronous single-port RAM behind the same valid/ready request interface, and adds:
- multi-beat incrementing bursts with address wrap-around;
- per-byte write strobes;
- a registered read-data channel with `rvalid_o`/`rlast_o` qualifiers.

It sits where `memory1` sits: directly behind a bus master or testbench driver. The storage array stays reachable for backdoor `$readmemh`/`$writememh`.

---
 rtl/memory_burst.sv | 159 +++++++++++++++
 tb/tb_memory_burst.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_burst.sv
// memory_burst: synchronous single-port RAM slave with incrementing,
// wrapping bursts, per-byte write strobes and a registered read channel.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i / ready_o     request handshake (command or write beat)
//   rd_wr_i, addr_i,      command fields (1 = write), sampled on command
//   len_i                 accept only; a burst is len_i+1 beats
//   wdata_i, wstrb_i      write beat data and byte enables
//   rdata_o, rvalid_o,    registered read beat, valid qualifier and
//   rlast_o               final-beat marker
//
// Storage is the top-level array `mem`, reachable hierarchically.
module memory_burst #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned LEN_WIDTH  = 3,
  parameter int unsigned STRB_WIDTH = WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  rd_wr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  rlast_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  logic [WIDTH-1:0] mem [DEPTH-1:0];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic                  ready_q, ready_d;

  logic                  hs_c;
  logic                  we_c;
  logic [ADDR_WIDTH-1:0] waddr_c;
  logic [WIDTH-1:0]      wword_c;

  assign hs_c = valid_i && ready_q;

  // Next-state, address/count sequencing and write-enable decode
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    we_c     = 1'b0;
    waddr_c  = addr_q;

    case (state_q)
      IDLE: begin
        if (hs_c) begin
          if (rd_wr_i) begin
            // The command beat doubles as write beat 0.
            we_c    = 1'b1;
            waddr_c = addr_i;
            if (len_i != '0) begin
              addr_d  = addr_i + ADDR_WIDTH'(1);
              beats_d = len_i - LEN_WIDTH'(1);
              state_d = WRITE;
            end
          end else begin
            addr_d  = addr_i;
            beats_d = len_i;
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (hs_c) begin
          we_c = 1'b1;
          if (beats_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            beats_d = beats_q - LEN_WIDTH'(1);
          end
        end
      end
      READ: begin
        rdata_d  = mem[addr_q];
        rvalid_d = 1'b1;
        if (beats_q == '0) begin
          rlast_d = 1'b1;
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          beats_d = beats_q - LEN_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // ready_o is a registered decode of the state being entered.
    ready_d = (state_d != READ);

    // A beat presented while reset is asserted is not committed.
    if (rst_i) we_c = 1'b0;
  end

  // Byte-lane merge of the write beat into the addressed word
  always_comb begin
    wword_c = mem[waddr_c];
    for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
      if (wstrb_i[k]) wword_c[8*k +: 8] = wdata_i[8*k +: 8];
    end
  end

  // Control and read-channel registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      beats_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      ready_q  <= ready_d;
    end
  end

  // Storage; deliberately not reset so preloaded contents survive
  always_ff @(posedge clk_i) begin
    if (we_c) mem[waddr_c] <= wword_c;
  end

  assign ready_o  = ready_q;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign rlast_o  = rlast_q;

endmodule

// File: tb/tb_memory_burst.sv
// tb_memory_burst: self-checking bench for memory_burst. A reference word
// model tracks every committed write; read commands push expected beats to
// a scoreboard queue that a negedge monitor pops as beats appear.
module tb_memory_burst;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 3;
  localparam int unsigned SW = 4;

  logic          clk;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic          rd_wr_i;
  logic [AW-1:0] addr_i;
  logic [LW-1:0] len_i;
  logic [W-1:0]  wdata_i;
  logic [SW-1:0] wstrb_i;
  logic [W-1:0]  rdata_o;
  logic          rvalid_o;
  logic          rlast_o;

  memory_burst #(
    .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STRB_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rd_wr_i(rd_wr_i), .addr_i(addr_i), .len_i(len_i), .wdata_i(wdata_i),
    .wstrb_i(wstrb_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .rlast_o(rlast_o)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] init;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [D];
  logic [31:0] wbuf [8];
  logic [3:0]  sbuf [8];
  exp_t        sb [$];
  exp_t        mon_e;
  vec_t        vt [6];
  int          zeros;
  int          beats;
  logic        done;
  logic [31:0] old6;
  logic [31:0] old7;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int k = 0; k < 4; k++) begin
      if (s[k]) model[a][8*k +: 8] = d[8*k +: 8];
    end
  endfunction

  // Write burst from wbuf/sbuf; optional stall of stall_n cycles before beat stall_at.
  // Command fields are scrambled after beat 0 since they must be ignored.
  task automatic wr_burst(input logic [3:0] a, input int len, input int stall_at, input int stall_n);
    for (int b = 0; b <= len; b++) begin
      if (b == stall_at) begin
        valid_i = 1'b0;
        repeat (stall_n) tick;
      end
      valid_i = 1'b1;
      rd_wr_i = (b == 0);
      addr_i  = (b == 0) ? a : ~a;
      len_i   = LW'(len);
      wdata_i = wbuf[b];
      wstrb_i = sbuf[b];
      chk("wr_ready", 32'(ready_o), 32'd1);
      tick;
      model_wr(a + 4'(b), wbuf[b], sbuf[b]);
    end
    valid_i = 1'b0;
  endtask

  // Issue a read command; expect the first n_exp beats of it.
  task automatic rd_cmd(input logic [3:0] a, input int len, input int n_exp);
    valid_i = 1'b1;
    rd_wr_i = 1'b0;
    addr_i  = a;
    len_i   = LW'(len);
    chk("rd_cmd_ready", 32'(ready_o), 32'd1);
    for (int k = 0; k < n_exp; k++) sb.push_back({model[a + 4'(k)], (k == len)});
    tick;
    valid_i = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick;
    chk("rd_drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Read-channel monitor
  always @(negedge clk) begin
    if (rvalid_o) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got beat %h, expected no beat", rdata_o);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_data", rdata_o, mon_e.data);
        chk("rd_last", 32'(rlast_o), 32'(mon_e.last));
      end
    end
    if (rlast_o && !rvalid_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL rlast_alone: got rlast 1 with rvalid 0, expected rlast 0");
    end
  end

  initial begin
    vt[0] = '{4'd2,  32'hFFFFFFFF, 32'h11223344, 4'b0101, 32'hFF22FF44};
    vt[1] = '{4'd9,  32'h00000000, 32'hAABBCCDD, 4'b1010, 32'hAA00CC00};
    vt[2] = '{4'd15, 32'h12345678, 32'h9ABCDEF0, 4'b0001, 32'h123456F0};
    vt[3] = '{4'd6,  32'h00000000, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
    vt[4] = '{4'd7,  32'h55555555, 32'hAAAAAAAA, 4'b1000, 32'hAA555555};
    vt[5] = '{4'd11, 32'h87654321, 32'h00FF00FF, 4'b0110, 32'h87FF0021};

    for (int i = 0; i < int'(D); i++) model[i] = 32'h0;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    rd_wr_i = 1'b0;
    addr_i  = '0;
    len_i   = '0;
    wdata_i = '0;
    wstrb_i = '0;

    // Reset and idle
    repeat (3) tick;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rlast", 32'(rlast_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst_i = 1'b0;
    tick;
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    wbuf[0] = 32'hDEADBEEF;
    sbuf[0] = 4'hF;
    wr_burst(4'd3, 0, -1, 0);
    rst_i = 1'b1;
    repeat (3) tick;
    chk("mem3_survives_rst", dut.mem[3], 32'hDEADBEEF);
    rst_i = 1'b0;
    tick;
    rd_cmd(4'd3, 0, 1);
    drain;

    // Single-beat write then read with latency check
    wbuf[0] = 32'h12345678;
    sbuf[0] = 4'hF;
    wr_burst(4'd5, 0, -1, 0);
    chk("single_wr_mem5", dut.mem[5], 32'h12345678);
    rd_cmd(4'd5, 0, 1);
    chk("single_rd_lat0_rvalid", 32'(rvalid_o), 32'd0);
    tick;
    chk("single_rd_rvalid", 32'(rvalid_o), 32'd1);
    chk("single_rd_rlast", 32'(rlast_o), 32'd1);
    chk("single_rd_rdata", rdata_o, 32'h12345678);
    tick;
    chk("single_rd_after_rvalid", 32'(rvalid_o), 32'd0);
    chk("single_rd_after_rlast", 32'(rlast_o), 32'd0);

    // Wrapping burst with a 2-cycle stall between beats 1 and 2
    for (int b = 0; b < 4; b++) begin
      wbuf[b] = 32'hA0 + 32'(b);
      sbuf[b] = 4'hF;
    end
    wr_burst(4'd14, 3, 2, 2);
    chk("wrap_mem14", dut.mem[14], 32'hA0);
    chk("wrap_mem15", dut.mem[15], 32'hA1);
    chk("wrap_mem0", dut.mem[0], 32'hA2);
    chk("wrap_mem1", dut.mem[1], 32'hA3);
    rd_cmd(4'd14, 3, 4);
    drain;

    // Byte strobe vectors
    for (int i = 0; i < 6; i++) begin
      wbuf[0] = vt[i].init;
      sbuf[0] = 4'hF;
      wr_burst(vt[i].addr, 0, -1, 0);
      wbuf[0] = vt[i].data;
      sbuf[0] = vt[i].strb;
      wr_burst(vt[i].addr, 0, -1, 0);
      chk("strb_mem", dut.mem[vt[i].addr], vt[i].exp);
      rd_cmd(vt[i].addr, 0, 1);
      drain;
    end
    wbuf[0] = 32'h00000000;
    sbuf[0] = 4'h0;
    wr_burst(4'd2, 0, -1, 0);
    chk("strb0_mem2", dut.mem[2], 32'hFF22FF44);

    // Back-to-back: 8-beat read, write accepted in the rlast cycle
    for (int b = 0; b < 8; b++) begin
      wbuf[b] = 32'(b + 1) * 32'h01010101;
      sbuf[b] = 4'hF;
    end
    wr_burst(4'd0, 7, -1, 0);
    rd_cmd(4'd0, 7, 8);
    valid_i = 1'b1;
    rd_wr_i = 1'b1;
    addr_i  = 4'd10;
    len_i   = '0;
    wdata_i = 32'hC0DE0010;
    wstrb_i = 4'hF;
    zeros   = 0;
    beats   = 0;
    done    = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (rvalid_o) beats++;
      if (!ready_o) begin
        zeros++;
        tick;
      end else begin
        done = 1'b1;
      end
    end
    chk("b2b_ready_back", 32'(done), 32'd1);
    chk("b2b_ready_low_cycles", 32'(zeros), 32'd8);
    chk("b2b_rvalid_beats", 32'(beats), 32'd8);
    chk("b2b_rlast_at_ready", 32'(rlast_o), 32'd1);
    tick;
    valid_i = 1'b0;
    model_wr(4'd10, 32'hC0DE0010, 4'hF);
    chk("b2b_wr_mem10", dut.mem[10], 32'hC0DE0010);
    chk("b2b_rvalid_drop", 32'(rvalid_o), 32'd0);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during beat 3 of an 8-beat read
    rd_cmd(4'd0, 7, 4);
    repeat (4) tick;
    chk("rstrd_beat3_rvalid", 32'(rvalid_o), 32'd1);
    rst_i = 1'b1;
    tick;
    chk("rstrd_rvalid", 32'(rvalid_o), 32'd0);
    chk("rstrd_rlast", 32'(rlast_o), 32'd0);
    chk("rstrd_ready", 32'(ready_o), 32'd0);
    chk("rstrd_sb_empty", 32'(sb.size()), 32'd0);
    rst_i = 1'b0;
    tick;
    chk("rstrd_ready_back", 32'(ready_o), 32'd1);
    repeat (3) tick;

    // Reset during beat 2 of a 4-beat write at address 4
    old6 = model[6];
    old7 = model[7];
    for (int b = 0; b < 3; b++) begin
      valid_i = 1'b1;
      rd_wr_i = (b == 0);
      addr_i  = 4'd4;
      len_i   = 3'd3;
      wdata_i = 32'hB0 + 32'(b);
      wstrb_i = 4'hF;
      if (b == 2) rst_i = 1'b1;
      tick;
      if (b < 2) model_wr(4'd4 + 4'(b), 32'hB0 + 32'(b), 4'hF);
    end
    valid_i = 1'b0;
    chk("rstwr_mem4", dut.mem[4], 32'hB0);
    chk("rstwr_mem5", dut.mem[5], 32'hB1);
    chk("rstwr_mem6", dut.mem[6], old6);
    chk("rstwr_mem7", dut.mem[7], old7);
    chk("rstwr_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b0;
    tick;
    chk("rstwr_ready_back", 32'(ready_o), 32'd1);
    rd_cmd(4'd4, 3, 4);
    drain;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
